// File: rtl/memory_bus_controller.sv
// Purpose: decodes CPU memory requests into ROM (below RAM_BASE) or RAM accesses
//          and sequences them through SETUP / ACCESS / DONE, with per-region wait states.
// Latency: WAIT+3 cycles for an accepted access, 1 cycle for a rejected one.
//          One access per WAIT+4 cycles.
// Backpressure: requests are sampled only in IDLE; a request held high is retaken
//               as a new request on the IDLE cycle after DONE.
// Ports:
//   clock/reset_n                  - single clock, async active-low reset
//   read_memory/write_memory       - CPU request strobes
//   address_in/write_data          - CPU request payload
//   read_data/ready/error          - captured read data, completion pulse, rejection flag
//   address_out                    - external address
//   external_data_bus              - external tri-state data bus
//   ram_enable/rom_enable          - active-low chip selects
//   write/read                     - active-high bus strobes
module memory_bus_controller #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 16'h2000,
    parameter int unsigned           ROM_WAIT   = 2,
    parameter int unsigned           RAM_WAIT   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  read_memory,
    input  logic                  write_memory,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] address_out,
    inout  wire  [DATA_WIDTH-1:0] external_data_bus,
    output logic                  ram_enable,
    output logic                  rom_enable,
    output logic                  write,
    output logic                  read
);

    localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    is_write_q;
    logic [3:0]              wait_q;
    logic                    ready_q;
    logic                    error_q;
    logic                    ram_cs_n_q;
    logic                    rom_cs_n_q;
    logic                    wr_stb_q;
    logic                    rd_stb_q;
    logic                    drive_q;

    // Request decode, only meaningful while IDLE.
    logic req_rom_d;
    logic reject_d;
    logic accept_d;

    assign req_rom_d = (address_in < RAM_BASE);
    assign reject_d  = (read_memory && write_memory) || (write_memory && req_rom_d);
    assign accept_d  = (read_memory ^ write_memory) && !reject_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            wait_q     <= 4'd0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            ram_cs_n_q <= 1'b1;
            rom_cs_n_q <= 1'b1;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            drive_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (reject_d) begin
                        // Rejected requests never touch the bus.
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                        error_q <= 1'b1;
                    end else if (accept_d) begin
                        // Chip select, address and write data are set up on entry
                        // to SETUP so they lead the strobe by one full cycle.
                        state_q    <= S_SETUP;
                        addr_q     <= address_in;
                        wdata_q    <= write_data;
                        is_write_q <= write_memory;
                        rom_cs_n_q <= !req_rom_d;
                        ram_cs_n_q <= req_rom_d;
                        drive_q    <= write_memory;
                        wait_q     <= req_rom_d ? ROM_WAIT_C : RAM_WAIT_C;
                    end
                end
                S_SETUP: begin
                    state_q  <= S_ACCESS;
                    rd_stb_q <= !is_write_q;
                    wr_stb_q <= is_write_q;
                end
                S_ACCESS: begin
                    if (wait_q == 4'd0) begin
                        state_q    <= S_DONE;
                        rd_stb_q   <= 1'b0;
                        wr_stb_q   <= 1'b0;
                        rom_cs_n_q <= 1'b1;
                        ram_cs_n_q <= 1'b1;
                        drive_q    <= 1'b0;
                        ready_q    <= 1'b1;
                        error_q    <= 1'b0;
                        if (!is_write_q) begin
                            rdata_q <= external_data_bus;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign external_data_bus = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign read_data   = rdata_q;
    assign ready       = ready_q;
    assign error       = error_q;
    assign address_out = addr_q;
    assign ram_enable  = ram_cs_n_q;
    assign rom_enable  = rom_cs_n_q;
    assign write       = wr_stb_q;
    assign read        = rd_stb_q;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Purpose: self-checking bench for memory_bus_controller (ROM_WAIT=2, RAM_WAIT=1).
// Latency: checks WAIT+3 access latency, 1-cycle rejection and WAIT+4 throughput.
// Backpressure: exercises held requests, mid-access reset and bus release.
module tb_memory_bus_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        read_memory = 1'b0;
    logic        write_memory = 1'b0;
    logic [15:0] address_in = 16'h0;
    logic [7:0]  write_data = 8'h0;
    logic [7:0]  read_data;
    logic        ready;
    logic        error;
    logic [15:0] address_out;
    wire  [7:0]  external_data_bus;
    logic        ram_enable;
    logic        rom_enable;
    logic        write;
    logic        read;

    logic        tb_oe = 1'b0;
    logic [7:0]  tb_val = 8'h0;

    assign external_data_bus = tb_oe ? tb_val : 8'hzz;

    memory_bus_controller dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .read_memory       (read_memory),
        .write_memory      (write_memory),
        .address_in        (address_in),
        .write_data        (write_data),
        .read_data         (read_data),
        .ready             (ready),
        .error             (error),
        .address_out       (address_out),
        .external_data_bus (external_data_bus),
        .ram_enable        (ram_enable),
        .rom_enable        (rom_enable),
        .write             (write),
        .read              (read)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  bv;
        int          err;
        int          lat;
        int          rom_lo;
        int          ram_lo;
        int          rd_hi;
        int          wr_hi;
        int          drv;
        logic [7:0]  rdata;
        logic [15:0] aout;
    } vec_t;

    // Reference state: last accepted address and last successfully read data.
    logic [7:0]  m_rdata;
    logic [15:0] m_addr;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Issue one request from IDLE (called at a negedge) and observe it to completion.
    task automatic apply(input string tag, input vec_t v);
        int lat, err, rom_lo, ram_lo, rd_hi, wr_hi, drv, rel, aout;
        lat = -1; err = -1; rom_lo = 0; ram_lo = 0; rd_hi = 0; wr_hi = 0;
        drv = 0; rel = 1; aout = -1;
        read_memory  = v.rd;
        write_memory = v.wr;
        address_in   = v.a;
        write_data   = v.wd;
        tb_oe        = !v.wr;
        tb_val       = v.bv;
        cycle();
        read_memory  = 1'b0;
        write_memory = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) aout = int'(address_out);
            if (!rom_enable) rom_lo++;
            if (!ram_enable) ram_lo++;
            if (read) rd_hi++;
            if (write) wr_hi++;
            if (v.wr && (!rom_enable || !ram_enable) && external_data_bus == v.wd) drv++;
            if (ready) begin
                lat = c;
                err = int'(error);
                if (v.wr) begin
                    // A released bus must take whatever the bench drives.
                    tb_oe  = 1'b1;
                    tb_val = ~v.wd;
                    #1;
                    rel    = (external_data_bus == ~v.wd) ? 1 : 0;
                    tb_oe  = 1'b0;
                end
                break;
            end
            cycle();
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " error"}, err, v.err);
        chk({tag, " rom_cs_cycles"}, rom_lo, v.rom_lo);
        chk({tag, " ram_cs_cycles"}, ram_lo, v.ram_lo);
        chk({tag, " read_cycles"}, rd_hi, v.rd_hi);
        chk({tag, " write_cycles"}, wr_hi, v.wr_hi);
        chk({tag, " read_data"}, int'(read_data), int'(v.rdata));
        chk({tag, " address_out"}, aout, int'(v.aout));
        if (v.wr) begin
            chk({tag, " bus_driven_cycles"}, drv, v.drv);
            chk({tag, " bus_released"}, rel, 1);
        end
        cycle();
        tb_oe = 1'b0;
    endtask

    // Build expectations from the access rules for a random request.
    function automatic vec_t model(input bit rd, input bit wr, input logic [15:0] a,
                                   input logic [7:0] wd, input logic [7:0] bv);
        vec_t v;
        bit   rom, rej;
        int   w;
        rom = (a < 16'h2000);
        w   = rom ? 2 : 1;
        rej = (rd && wr) || (wr && rom);
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.bv = bv;
        v.err    = rej ? 1 : 0;
        v.lat    = rej ? 1 : w + 3;
        v.rom_lo = (!rej && rom) ? w + 2 : 0;
        v.ram_lo = (!rej && !rom) ? w + 2 : 0;
        v.rd_hi  = (!rej && rd) ? w + 1 : 0;
        v.wr_hi  = (!rej && wr) ? w + 1 : 0;
        v.drv    = (!rej && wr) ? w + 2 : 0;
        if (!rej) begin
            m_addr = a;
            if (rd) m_rdata = bv;
        end
        v.rdata = m_rdata;
        v.aout  = m_addr;
        return v;
    endfunction

    // Hold a read request high; check completion spacing and read_data update points.
    task automatic hold_reads(input string tag, input logic [15:0] a, input int gap, input int n_exp);
        int         rdy[$];
        int         bad_upd, bad_val;
        logic [7:0] prev;
        bad_upd = 0; bad_val = 0;
        prev = read_data;
        read_memory = 1'b1;
        address_in  = a;
        tb_oe       = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (ready) begin
                rdy.push_back(c);
                if (read_data != 8'(c - 1)) bad_val++;
            end else if (read_data != prev) begin
                bad_upd++;
            end
            prev   = read_data;
            tb_val = 8'(c);
            cycle();
        end
        read_memory = 1'b0;
        repeat (8) cycle();
        tb_oe = 1'b0;
        chk({tag, " ready_count"}, rdy.size(), n_exp);
        if (rdy.size() > 0) chk({tag, " first_ready"}, rdy[0], gap - 1);
        for (int i = 1; i < rdy.size(); i++) chk({tag, " ready_gap"}, rdy[i] - rdy[i-1], gap);
        chk({tag, " read_data_stray_updates"}, bad_upd, 0);
        chk({tag, " read_data_captured"}, bad_val, 0);
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h1FFF, 8'h00, 8'hA5, 0, 5, 4, 0, 3, 0, 0, 8'hA5, 16'h1FFF};
        tbl[1] = '{1'b0, 1'b1, 16'h2000, 8'h3C, 8'h00, 0, 4, 0, 3, 0, 2, 3, 8'hA5, 16'h2000};
        tbl[2] = '{1'b0, 1'b1, 16'h1FFE, 8'h11, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'hA5, 16'h2000};
        tbl[3] = '{1'b1, 1'b1, 16'hFFFF, 8'h22, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'hA5, 16'h2000};
        tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h5A, 0, 4, 0, 3, 2, 0, 0, 8'h5A, 16'hFFFF};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'hC3, 0, 5, 4, 0, 3, 0, 0, 8'hC3, 16'h0000};
        tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 8'h81, 8'h00, 0, 4, 0, 3, 0, 2, 3, 8'hC3, 16'hFFFF};
        tbl[7] = '{1'b1, 1'b0, 16'h2000, 8'h00, 8'h0F, 0, 4, 0, 3, 2, 0, 0, 8'h0F, 16'h2000};
        tbl[8] = '{1'b0, 1'b1, 16'h0000, 8'hE7, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h0F, 16'h2000};

        // Reset state, observed while reset is still asserted.
        #2 reset_n = 1'b0;
        tb_oe  = 1'b1;
        tb_val = 8'h5A;
        #1;
        chk("reset address_out", int'(address_out), 0);
        chk("reset read_data", int'(read_data), 0);
        chk("reset ready", int'(ready), 0);
        chk("reset error", int'(error), 0);
        chk("reset write", int'(write), 0);
        chk("reset read", int'(read), 0);
        chk("reset ram_enable", int'(ram_enable), 1);
        chk("reset rom_enable", int'(rom_enable), 1);
        chk("reset bus_released", int'(external_data_bus), 8'h5A);
        tb_oe = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        cycle();

        for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i]);

        m_rdata = 8'h0F;
        m_addr  = 16'h2000;
        for (int i = 0; i < 40; i++) begin
            int          mode, asel;
            logic [15:0] a;
            mode = $urandom_range(0, 2);
            asel = $urandom_range(0, 4);
            case (asel)
                0:       a = 16'h1FFF;
                1:       a = 16'h2000;
                2:       a = 16'hFFFF;
                3:       a = 16'h0000;
                default: a = 16'($urandom);
            endcase
            apply($sformatf("rnd%0d", i),
                  model(mode != 1, mode != 0, a, 8'($urandom), 8'($urandom)));
        end

        // Reset pulsed during ACCESS of a RAM read.
        begin
            int found;
            found = 0;
            read_memory = 1'b1;
            address_in  = 16'h2000;
            tb_oe       = 1'b1;
            tb_val      = 8'h99;
            for (int c = 0; c < 10; c++) begin
                cycle();
                if (read) begin
                    found = 1;
                    break;
                end
            end
            chk("midreset reached_access", found, 1);
            reset_n     = 1'b0;
            read_memory = 1'b0;
            #1;
            chk("midreset read", int'(read), 0);
            chk("midreset ram_enable", int'(ram_enable), 1);
            chk("midreset ready", int'(ready), 0);
            chk("midreset address_out", int'(address_out), 0);
            chk("midreset read_data", int'(read_data), 0);
            @(negedge clock);
            reset_n = 1'b1;
            found = 0;
            for (int c = 0; c < 8; c++) begin
                if (ready) found++;
                cycle();
            end
            chk("midreset no_ready", found, 0);
            chk("midreset read_data_after", int'(read_data), 0);
            tb_oe = 1'b0;
            m_rdata = 8'h00;
            m_addr  = 16'h0000;
            apply("post_reset_read", model(1'b1, 1'b0, 16'h2000, 8'h00, 8'h77));
        end

        hold_reads("b2b_rom", 16'h0100, 6, 6);
        hold_reads("b2b_ram", 16'h3000, 5, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
